// File: rtl/ofifo.sv
// Opaque elastic FIFO: circular buffer of NUM_SLOTS tokens, all outputs driven from registers.
// Latency: one cycle from accepted input to outs_valid; no bypass path.
// Backpressure: ins_ready = not full (from state only); a freed slot is offered the cycle after a read.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (rst=0 clears all state)
//   ins         input token data
//   ins_valid   input token present
//   ins_ready   FIFO has a free slot this cycle
//   outs        token at head slot
//   outs_valid  FIFO holds at least one token
//   outs_ready  consumer takes the head token this cycle
module ofifo #(
   parameter int NUM_SLOTS = 2,
   parameter int DATA_TYPE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] ins,
   input  logic                 ins_valid,
   output logic                 ins_ready,
   output logic [DATA_TYPE-1:0] outs,
   output logic                 outs_valid,
   input  logic                 outs_ready
);

   localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int CW = $clog2(NUM_SLOTS + 1);
   localparam logic [PW-1:0] LAST_PTR  = PW'(NUM_SLOTS - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_SLOTS);

   logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
   logic [PW-1:0]        head_q, head_d;
   logic [PW-1:0]        tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 wr_en, rd_en;

   // Handshake flags depend only on the occupancy register, so neither
   // ins_ready nor outs_valid has a combinational path from the inputs.
   assign outs_valid = (count_q != '0);
   assign ins_ready  = (count_q != FULL_CNT);
   assign outs       = mem_q[head_q];

   assign wr_en = ins_valid  && ins_ready;
   assign rd_en = outs_valid && outs_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      // Explicit wrap so non-power-of-two depths never index past the last slot.
      if (wr_en) begin
         tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PW'(1);
      end
      if (rd_en) begin
         head_d = (head_q == LAST_PTR) ? '0 : head_q + PW'(1);
      end

      if (wr_en && !rd_en) begin
         count_d = count_q + CW'(1);
      end else if (rd_en && !wr_en) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (wr_en) begin
            mem_q[tail_q] <= ins;
         end
      end
   end

endmodule

// File: tb/tb_ofifo.sv
// Bench for ofifo: four instances (NUM_SLOTS = 1..4, 8-bit data) share one
// randomized stimulus; each is checked every cycle against a queue model,
// plus directed scenarios with hand-computed literal expectations.
module tb_ofifo;

   localparam int NI = 4;

   logic          clk;
   logic          rst;
   logic [7:0]    ins;
   logic          ins_valid;
   logic          outs_ready;
   logic [NI-1:0] ins_ready_w;
   logic [NI-1:0] outs_valid_w;
   logic [7:0]    outs_w [NI];

   int checks = 0;
   int errors = 0;

   // Instance g has NUM_SLOTS = g+1.
   for (genvar g = 0; g < NI; g++) begin : g_dut
      ofifo #(.NUM_SLOTS(g + 1), .DATA_TYPE(8)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .ins        (ins),
         .ins_valid  (ins_valid),
         .ins_ready  (ins_ready_w[g]),
         .outs       (outs_w[g]),
         .outs_valid (outs_valid_w[g]),
         .outs_ready (outs_ready)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue of stored tokens per instance.
   logic [7:0] mq [NI][$];

   always @(posedge clk or negedge rst) begin
      int  n;
      bit  r, w;
      if (!rst) begin
         for (int i = 0; i < NI; i++) mq[i].delete();
      end else begin
         for (int i = 0; i < NI; i++) begin
            n = mq[i].size();
            r = (n > 0) && outs_ready;
            w = ins_valid && (n < i + 1);
            if (r) void'(mq[i].pop_front());
            if (w) mq[i].push_back(ins);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every instance against the model.
   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("valid[%0d]", i), int'(outs_valid_w[i]), int'(mq[i].size() != 0));
         chk($sformatf("ready[%0d]", i), int'(ins_ready_w[i]), int'(mq[i].size() != i + 1));
         if (mq[i].size() != 0)
            chk($sformatf("outs[%0d]", i), int'(outs_w[i]), int'(mq[i][0]));
      end
   endtask

   // Inputs set at a negedge apply at the next posedge; return at the
   // following negedge with outputs compared.
   task automatic cyc();
      @(posedge clk);
      #1;
      @(negedge clk);
      compare_all();
   endtask

   task automatic drain();
      ins_valid  = 1'b0;
      outs_ready = 1'b1;
      repeat (6) cyc();
   endtask

   initial begin
      logic [7:0] v;
      bit         acc;

      rst = 1'b0;
      ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;

      // Reset held with random inputs: outputs must sit at reset values.
      repeat (5) begin
         ins        = 8'($urandom);
         ins_valid  = 1'($urandom);
         outs_ready = 1'($urandom);
         cyc();
         chk("rst_outs", int'(outs_w[1]), 0);
         chk("rst_valid", int'(outs_valid_w[1]), 0);
      end
      ins_valid = 1'b0; outs_ready = 1'b0;
      rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("rel_valid", int'(outs_valid_w[i]), 0);
         chk("rel_ready", int'(ins_ready_w[i]), 1);
         chk("rel_outs", int'(outs_w[i]), 0);
      end

      // Single token on NUM_SLOTS=2.
      @(negedge clk);
      ins = 8'hA5; ins_valid = 1'b1; outs_ready = 1'b1;
      cyc();
      chk("single_outs", int'(outs_w[1]), 8'hA5);
      chk("single_valid", int'(outs_valid_w[1]), 1);
      ins_valid = 1'b0;
      cyc();
      chk("single_gone", int'(outs_valid_w[1]), 0);

      // Streaming 0..9 on NUM_SLOTS=2.
      for (int k = 0; k < 10; k++) begin
         chk("stream_ready", int'(ins_ready_w[1]), 1);
         ins = 8'(k); ins_valid = 1'b1;
         cyc();
         chk("stream_outs", int'(outs_w[1]), k);
         chk("stream_valid", int'(outs_valid_w[1]), 1);
      end
      drain();

      // Fill and drain on NUM_SLOTS=4.
      outs_ready = 1'b0;
      v = 8'h10;
      repeat (6) begin
         ins = v; ins_valid = 1'b1;
         acc = ins_ready_w[3];
         cyc();
         if (acc) v++;
      end
      chk("fill_next", int'(v), 8'h14);
      chk("fill_full", int'(ins_ready_w[3]), 0);
      chk("fill_head", int'(outs_w[3]), 8'h10);
      outs_ready = 1'b1;
      cyc();
      chk("drain_ready", int'(ins_ready_w[3]), 1);
      chk("drain_o1", int'(outs_w[3]), 8'h11);
      cyc();
      ins_valid = 1'b0;
      chk("drain_o2", int'(outs_w[3]), 8'h12);
      cyc();
      chk("drain_o3", int'(outs_w[3]), 8'h13);
      cyc();
      chk("drain_o4", int'(outs_w[3]), 8'h14);
      drain();

      // Wrap with simultaneous read/write on NUM_SLOTS=3.
      outs_ready = 1'b0; ins_valid = 1'b1;
      repeat (2) begin
         ins = 8'($urandom);
         cyc();
      end
      outs_ready = 1'b1;
      repeat (10) begin
         ins = 8'($urandom);
         cyc();
         chk("wrap_ready", int'(ins_ready_w[2]), 1);
         chk("wrap_valid", int'(outs_valid_w[2]), 1);
      end
      outs_ready = 1'b0; ins = 8'($urandom);
      cyc();
      chk("wrap_full", int'(ins_ready_w[2]), 0);
      outs_ready = 1'b1; ins = 8'($urandom);
      cyc();
      chk("wrap_refused", int'(ins_ready_w[2]), 1);
      drain();

      // Asynchronous reset mid-operation with 3 tokens in NUM_SLOTS=4.
      outs_ready = 1'b0; ins_valid = 1'b1;
      repeat (3) begin
         ins = 8'($urandom);
         cyc();
      end
      ins_valid = 1'b0;
      chk("pre_rst_valid", int'(outs_valid_w[3]), 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", int'(outs_valid_w[3]), 0);
      chk("arst_ready", int'(ins_ready_w[3]), 1);
      chk("arst_outs", int'(outs_w[3]), 0);
      @(negedge clk);
      rst = 1'b1;
      ins = 8'h7E; ins_valid = 1'b1;
      cyc();
      ins_valid = 1'b0;
      chk("post_outs", int'(outs_w[3]), 8'h7E);
      chk("post_valid", int'(outs_valid_w[3]), 1);
      outs_ready = 1'b1;
      cyc();
      chk("post_empty", int'(outs_valid_w[3]), 0);

      // Randomized traffic, model-checked every cycle.
      repeat (500) begin
         ins        = 8'($urandom);
         ins_valid  = ($urandom_range(0, 3) != 0);
         outs_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ofifo.md
# ofifo

Opaque elastic FIFO for the handshake library. It is the registered counterpart of the transparent FIFO: every output is driven from state only, so it cuts both the valid/data path and the ready path between producer and consumer. It is used where the dataflow netlist needs a full timing break plus NUM_SLOTS tokens of slack on a data-carrying channel. Storage is a circular buffer with head/tail pointers and an occupancy counter, self-contained with no inner FIFO instance.

## Interface
- NUM_SLOTS, 2: number of storage slots; must be ≥1; any value, not just powers of two.
- DATA_TYPE, 32: data width in bits; must be ≥1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low (rst=0 resets).
- ins  in  DATA_TYPE  input token data.
- ins_valid  in  1  input token present.
- ins_ready  out  1  FIFO accepts a token this cycle.
- outs  out  DATA_TYPE  output token data (slot at head).
- outs_valid  out  1  output token present.
- outs_ready  in  1  consumer accepts this cycle.

## Operation
- State:
  - mem[NUM_SLOTS] of DATA_TYPE.
  - head and tail pointers, each max($clog2(NUM_SLOTS),1) bits.
  - count, $clog2(NUM_SLOTS+1) bits.
- Reset while rst=0, asynchronous and held for as long as rst is low: head=0, tail=0, count=0, all mem slots=0.
- Derived outputs are pure functions of registers, with no combinational input→output path:
  - outs_valid = (count≠0)
  - ins_ready = (count≠NUM_SLOTS)
  - outs = mem[head]
- Write = ins_valid && ins_ready. On a write: mem[tail]←ins and tail advances.
- Read = outs_valid && outs_ready. On a read: head advances.
- Pointer advance: if ptr==NUM_SLOTS-1 then ptr←0, else ptr+1. Wrap is explicit; modulo 2^width is not used.
- count update:
  - +1 on write only.
  - −1 on read only.
  - unchanged on simultaneous write and read, or on neither.
- Ordering is strictly FIFO. Data is never modified, dropped or duplicated.
- Full (count=NUM_SLOTS): ins_ready=0, so no write that cycle even if outs_ready=1. The freed slot is offered the next cycle.
- Empty (count=0): outs_valid=0, so no read that cycle. A token written this cycle appears on outs the next cycle.
- outs_valid and outs hold stable while outs_valid=1 and outs_ready=0. The producer side sees ins_ready stable unless a read occurs.
- Reset mid-operation discards all stored tokens immediately. Outputs go to reset values within the same cycle, with no clock needed.

## Timing
- Reset values of outputs: outs_valid=0, ins_ready=1, outs=0.
- Latency: a token accepted at edge N is visible on outs with outs_valid=1 after edge N. This is exactly one cycle of forward latency; there is no bypass.
- Throughput:
  - NUM_SLOTS≥2: one token per cycle sustained when outs_ready is held high.
  - NUM_SLOTS=1: one token every 2 cycles.
- Backpressure latency: a read at edge N raises ins_ready after edge N if the FIFO was full.
- Timing-path check: no combinational path from ins_valid/ins/outs_ready to any output.

## Test plan
- Reset, NUM_SLOTS=2, DATA_TYPE=8: hold rst=0 with random inputs, then release → outs_valid=0, ins_ready=1, outs=0. No outputs toggle while rst=0.
- Single token: drive ins=0xA5 with ins_valid=1 for one cycle, outs_ready=1 → the following cycle shows outs=0xA5 and outs_valid=1 for exactly one cycle, then outs_valid=0.
- Streaming, NUM_SLOTS=2: send 0..9 on consecutive cycles with outs_ready=1 → outs shows 0..9 on 10 consecutive cycles, one cycle after input, and ins_ready stays 1 throughout.
- Fill and drain, NUM_SLOTS=4: hold outs_ready=0 and offer 0x10..0x15.
  - Only 0x10..0x13 are accepted; ins_ready=0 after the 4th write.
  - Then set outs_ready=1 → outs gives 0x10, 0x11, 0x12, 0x13, and the 5th write (0x14) occurs the cycle after the first read.
- Wrap and simultaneous access, NUM_SLOTS=3: preload 2 tokens, then drive ins_valid=1 and outs_ready=1 for 10 cycles with random data.
  - count stays at 2 and order is preserved across the pointer wrap 2→0.
  - With the FIFO full and outs_ready=1, the write is refused for that cycle.
- Reset mid-operation: with 3 tokens stored in NUM_SLOTS=4, pulse rst=0 asynchronously between edges → outs_valid=0 and ins_ready=1 immediately. After release, a new token 0x7E is the first and only token output.
